// File: rtl/gtx_rx_pkg.sv
// gtx_rx_pkg: link-state type, default sizes and per-channel slice helper for the GTX receive monitor
package gtx_rx_pkg;
    typedef enum logic [1:0] {
        DOWN   = 2'd0,
        SETTLE = 2'd1,
        UP     = 2'd2
    } link_state_e;
    localparam int NCH_DEF   = 7;
    localparam int DW_DEF    = 48;
    localparam int DLY_W_DEF = 4;
    localparam int ERR_W_DEF = 16;
    // Low bit of channel ch on a bus packed w bits per channel.
    function automatic int slice_lo(input int ch, input int w);
        return ch * w;
    endfunction
endpackage

// File: rtl/gtx_rx_chan.sv
// gtx_rx_chan: one fiber channel - link FSM with settle timer, bx delay RAM, PRBS error counter
//   and, when GTX_RX_LOSS_CNT_EN is defined, a saturating loss-of-sync counter.
module gtx_rx_chan
    import gtx_rx_pkg::*;
#(
    parameter int DW            = DW_DEF,
    parameter int DLY_W         = DLY_W_DEF,
    parameter int ERR_W         = ERR_W_DEF,
    parameter int SETTLE_CYCLES = 3000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lock_i,
    input  logic             valid_i,
    input  logic             match_i,
    input  logic             prbs_en_i,
    input  logic             clr_i,
    input  logic [DLY_W-1:0] wr_ptr_i,
    input  logic [DLY_W-1:0] delay_i,
    input  logic [DW-1:0]    data_i,
    output logic [DW-1:0]    data_o,
    output logic             link_up_o,
    output logic             link_err_o,
    output logic             err_sat_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [7:0]       loss_cnt_o
);
    localparam int CW    = $clog2(SETTLE_CYCLES + 1);
    localparam int DEPTH = 1 << DLY_W;

    link_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    data_q;
    logic [ERR_W-1:0] err_q;
    logic             err_pulse_q;
    logic [DLY_W-1:0] rd_idx;
    logic             err_hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DOWN: begin
                state_d = lock_i ? SETTLE : DOWN;
                cnt_d   = lock_i ? CW'(SETTLE_CYCLES - 1) : cnt_q;
            end
            SETTLE: begin
                state_d = !lock_i ? DOWN : (cnt_q == '0) ? UP : SETTLE;
                cnt_d   = (lock_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
            end
            UP:      state_d = lock_i ? UP : DOWN;
            default: state_d = DOWN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DOWN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign link_up_o = state_q == UP;
    assign rd_idx    = wr_ptr_i - delay_i;
    assign err_hit   = link_up_o & prbs_en_i & valid_i & ~match_i;

    // Zero delay bypasses the RAM: the slot at wr_ptr is only being written this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            data_q <= '0;
        end else begin
            mem_q[wr_ptr_i] <= data_i;
            data_q          <= (delay_i == '0) ? data_i : mem_q[rd_idx];
        end
    end

    assign data_o = link_up_o ? data_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q       <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_hit;
            err_q       <= clr_i ? '0 : (err_hit && !err_sat_o) ? err_q + 1'b1 : err_q;
        end
    end

    assign err_sat_o  = &err_q;
    assign err_cnt_o  = err_q;
    assign link_err_o = err_pulse_q;

`ifdef GTX_RX_LOSS_CNT_EN
    logic [7:0] loss_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) loss_q <= '0;
        else         loss_q <= clr_i ? '0 : (link_up_o && !lock_i && !(&loss_q)) ? loss_q + 8'd1 : loss_q;
    end
    assign loss_cnt_o = loss_q;
`else
    assign loss_cnt_o = 8'd0;
`endif
endmodule

// File: rtl/gtx_rx_link_monitor.sv
// gtx_rx_link_monitor: NCH-channel GTX receive link monitor with per-channel delay, link FSM and error readout
//   GTX_RX_LOSS_CNT_EN enables the per-channel loss-of-sync counters behind loss_count_rd.
module gtx_rx_link_monitor
    import gtx_rx_pkg::*;
#(
    parameter int NCH           = NCH_DEF,
    parameter int DW            = DW_DEF,
    parameter int DLY_W         = DLY_W_DEF,
    parameter int ERR_W         = ERR_W_DEF,
    parameter int SETTLE_CYCLES = 3000
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     qpll_lock,
    input  logic [NCH-1:0]           rx_sync_done,
    input  logic [NCH-1:0]           rx_valid,
    input  logic [NCH-1:0]           rx_match,
    input  logic [NCH*DW-1:0]        rx_data,
    input  logic [NCH*DLY_W-1:0]     delay_is,
    input  logic                     prbs_en,
    input  logic                     err_cnt_clr,
    input  logic [$clog2(NCH)-1:0]   rd_sel,
    output logic [NCH*DW-1:0]        data_out,
    output logic [NCH-1:0]           link_up,
    output logic                     all_up,
    output logic [NCH-1:0]           link_err,
    output logic [NCH-1:0]           err_sat,
    output logic [ERR_W-1:0]         err_count_rd,
    output logic [7:0]               loss_count_rd
);
    logic [DLY_W-1:0] wr_ptr_q;
    logic [ERR_W-1:0] err_cnt [NCH];
    logic [7:0]       loss_cnt [NCH];
    logic [ERR_W-1:0] err_rd_q;
    logic [7:0]       loss_rd_q;
    logic             rd_ok;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gtx_rx_chan #(
            .DW            (DW),
            .DLY_W         (DLY_W),
            .ERR_W         (ERR_W),
            .SETTLE_CYCLES (SETTLE_CYCLES)
        ) u_chan (
            .clk_i      (clock),
            .rst_ni     (reset_n),
            .lock_i     (qpll_lock & rx_sync_done[i]),
            .valid_i    (rx_valid[i]),
            .match_i    (rx_match[i]),
            .prbs_en_i  (prbs_en),
            .clr_i      (err_cnt_clr),
            .wr_ptr_i   (wr_ptr_q),
            .delay_i    (delay_is[slice_lo(i, DLY_W) +: DLY_W]),
            .data_i     (rx_data[slice_lo(i, DW) +: DW]),
            .data_o     (data_out[slice_lo(i, DW) +: DW]),
            .link_up_o  (link_up[i]),
            .link_err_o (link_err[i]),
            .err_sat_o  (err_sat[i]),
            .err_cnt_o  (err_cnt[i]),
            .loss_cnt_o (loss_cnt[i])
        );
    end

    assign rd_ok = 32'(rd_sel) < NCH;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            err_rd_q  <= '0;
            loss_rd_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_q + 1'b1;
            err_rd_q  <= rd_ok ? err_cnt[rd_sel] : '0;
            loss_rd_q <= rd_ok ? loss_cnt[rd_sel] : '0;
        end
    end

    assign all_up        = &link_up;
    assign err_count_rd  = err_rd_q;
    assign loss_count_rd = loss_rd_q;
endmodule
